mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Initiator side of the word-wide data-memory port: sits between the pipeline MEM stage and the data memory, turning load/store requests into word-aligned memory transactions. It drives address, write data and write enable into the combinational-read, write-on-clock memory. It performs byte/halfword stores as read-modify-write and byte/halfword loads with sign or zero extension. Misaligned, illegal or out-of-range requests are reported as faults.

## Interface
Parameters:
- MEM_WORDS, 1024: words in the attached memory; byte addresses ≥ MEM_WORDS*4 fault.

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-low (0 = reset asserted)
- reqValid  in  1  request present
- reqWrite  in  1  1 = store, 0 = load
- reqSize  in  2  00 byte, 01 half, 10 word, 11 illegal
- reqSigned  in  1  loads: 1 sign-extend, 0 zero-extend
- reqAddress  in  32  byte address
- reqWriteData  in  32  store data, right-justified
- reqPC  in  32  PC of requesting instruction
- reqReady  out  1  request accepted when reqValid & reqReady
- respValid  out  1  one-cycle completion pulse
- respData  out  32  extended load data (0 for stores/faults)
- addrError  out  1  qualifies respValid: request faulted
- memAddress  out  32  word-aligned address to memory
- memWriteData  out  32  word to write
- memWriteEnable  out  1  write strobe
- memReadData  in  32  combinational read of memAddress
- memDebugPC  out  32  latched reqPC forwarded to memory

## Operation
- States: IDLE, LOAD, RMW_READ, WRITE, FAULT. reqReady = (state==IDLE) & reset.
- IDLE accept: latch address, size, signed, data, PC. Fault if reqSize==11, half with addr[0]≠0, word with addr[1:0]≠0, or addr ≥ MEM_WORDS*4 → FAULT. Else load → LOAD; word store → WRITE; byte/half store → RMW_READ.
- Lanes little-endian: byte k = addr[1:0] at [8k+7:8k]; half at [16·addr[1]+15:16·addr[1]].
- LOAD: drive memAddress; at edge register extracted/extended lane into respData, respValid←1; → IDLE.
- RMW_READ: drive memAddress; capture memReadData into merge register with new byte/half inserted from reqWriteData low bits; → WRITE.
- WRITE: memWriteEnable=1, memWriteData = reqWriteData (word) or merged word; at edge respValid←1, respData←0; → IDLE.
- FAULT: no memory access; at edge respValid←1, addrError←1, respData←0; → IDLE.
- memAddress = {latchedAddr[31:2],2'b00} outside IDLE, else 0. memWriteData 0 unless WRITE. memWriteEnable = (state==WRITE) & reset.
- respValid/addrError are registered, high exactly one cycle.

## Timing
- Accept edge = edge 0. Load/word store/fault: respValid high in cycle after edge 1. Sub-word store: read at cycle 1, write at cycle 2, respValid after edge 2.
- New request accepted in the same cycle respValid is high (state already IDLE).
- reqValid outside IDLE ignored; requester holds it until accepted.
- Reset (reset=0 at edge): state→IDLE, respValid, addrError, respData, latched regs→0. memWriteEnable and reqReady forced 0 combinationally while reset=0, so an in-flight WRITE is dropped. Outstanding request is abandoned with no response.
- Reset value of every output: 0.

## Configuration
- SUBWORD_EN defined: byte/half loads and stores supported as above, RMW_READ present.
- Undefined: reqSize 00/01 treated as illegal → FAULT. RMW_READ and merge register not built. Word behaviour unchanged.

## Test plan
- Word store 0x0000_0010 ← 0xDEADBEEF: memWriteEnable one cycle, memAddress 0x10, memWriteData 0xDEADBEEF, respValid next cycle, addrError 0.
- With memory word 0x11223344 at 0x20, byte store 0x21 ← 0xAA: read at 0x20, write 0x1122AA44, respValid two cycles after accept.
- Memory 0x8000FF80 at 0x30: signed byte load 0x30 → 0xFFFFFF80. Unsigned half load 0x32 → 0x00008000. Signed half load 0x30 → 0xFFFFFF80.
- Word load at 0x06, half at 0x01, reqSize 11, address 0x1000 (MEM_WORDS=1024): each gives respValid+addrError, no memWriteEnable.
- reset→0 during WRITE cycle of a store: memWriteEnable 0, memory unchanged, no respValid. After release, reqReady=1.
- Back-to-back: new load asserted in respValid cycle of prior store is accepted that cycle; respValid pulses are separated by one idle-free cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator for a word-wide data memory
// Optional macro SUBWORD_EN: byte/halfword access via read-modify-write.
module mem_access_unit #(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        reqValid,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqSigned,
  input  logic [31:0] reqAddress,
  input  logic [31:0] reqWriteData,
  input  logic [31:0] reqPC,
  output logic        reqReady,
  output logic        respValid,
  output logic [31:0] respData,
  output logic        addrError,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic        memWriteEnable,
  input  logic [31:0] memReadData,
  output logic [31:0] memDebugPC
);

`ifdef SUBWORD_EN
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    FAULT    = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WRITE = 3'd3,
    FAULT = 3'd4
  } state_t;
`endif

  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  state_t      state;
  state_t      state_next;
  logic        accept;
  logic        req_fault;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [31:0] pc_q;
`ifdef SUBWORD_EN
  logic [31:0] merge_q;
`endif

  // Little-endian lane select with optional sign extension.
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] offs,
                                              input logic [1:0] size, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {offs, 3'b000});
    h = 16'(word >> {offs[1], 4'b0000});
    case (size)
      2'b00:   return {{24{sgn & b[7]}}, b};
      2'b01:   return {{16{sgn & h[15]}}, h};
      default: return word;
    endcase
  endfunction

`ifdef SUBWORD_EN
  function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [1:0] offs,
                                             input logic [1:0] size, input logic [31:0] data);
    logic [31:0] mask;
    logic [31:0] ins;
    if (size == 2'b00) begin
      mask = 32'h0000_00FF << {offs, 3'b000};
      ins  = {24'b0, data[7:0]} << {offs, 3'b000};
    end else begin
      mask = 32'h0000_FFFF << {offs[1], 4'b0000};
      ins  = {16'b0, data[15:0]} << {offs[1], 4'b0000};
    end
    return (word & ~mask) | ins;
  endfunction
`endif

  assign accept = reqValid & reqReady;

  always_comb begin
    req_fault = 1'b0;
    case (reqSize)
      2'b10:   req_fault = (reqAddress[1:0] != 2'b00);
`ifdef SUBWORD_EN
      2'b01:   req_fault = reqAddress[0];
      2'b00:   req_fault = 1'b0;
`endif
      default: req_fault = 1'b1;
    endcase
    if ({1'b0, reqAddress} >= ADDR_LIMIT) req_fault = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    reqReady       = (state == IDLE) & reset;
    memAddress     = 32'd0;
    memWriteData   = 32'd0;
    memWriteEnable = 1'b0;
    if (state != IDLE) memAddress = {addr_q[31:2], 2'b00};
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_fault)     state_next = FAULT;
          else if (!reqWrite) state_next = LOAD;
`ifdef SUBWORD_EN
          else if (reqSize != 2'b10) state_next = RMW_READ;
`endif
          else               state_next = WRITE;
        end
      end
`ifdef SUBWORD_EN
      RMW_READ: state_next = WRITE;
`endif
      WRITE: begin
        memWriteEnable = reset;
`ifdef SUBWORD_EN
        memWriteData   = (size_q == 2'b10) ? wdata_q : merge_q;
`else
        memWriteData   = wdata_q;
`endif
        state_next     = IDLE;
      end
      LOAD:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      respValid <= 1'b0;
      addrError <= 1'b0;
      respData  <= 32'd0;
      addr_q    <= 32'd0;
      size_q    <= 2'd0;
      signed_q  <= 1'b0;
      wdata_q   <= 32'd0;
      pc_q      <= 32'd0;
`ifdef SUBWORD_EN
      merge_q   <= 32'd0;
`endif
    end else begin
      respValid <= 1'b0;
      addrError <= 1'b0;
      respData  <= 32'd0;
      if (accept) begin
        addr_q   <= reqAddress;
        size_q   <= reqSize;
        signed_q <= reqSigned;
        wdata_q  <= reqWriteData;
        pc_q     <= reqPC;
      end
      case (state)
        LOAD: begin
          respValid <= 1'b1;
          respData  <= load_extend(memReadData, addr_q[1:0], size_q, signed_q);
        end
`ifdef SUBWORD_EN
        RMW_READ: merge_q <= merge_lane(memReadData, addr_q[1:0], size_q, wdata_q);
`endif
        WRITE: respValid <= 1'b1;
        FAULT: begin
          respValid <= 1'b1;
          addrError <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign memDebugPC = pc_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed self-checking bench for mem_access_unit
// Subword expectations follow the SUBWORD_EN build option.
module tb_mem_access_unit;
  logic        clk;
  logic        reset;
  logic        reqValid;
  logic        reqWrite;
  logic [1:0]  reqSize;
  logic        reqSigned;
  logic [31:0] reqAddress;
  logic [31:0] reqWriteData;
  logic [31:0] reqPC;
  logic        reqReady;
  logic        respValid;
  logic [31:0] respData;
  logic        addrError;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic        memWriteEnable;
  logic [31:0] memReadData;
  logic [31:0] memDebugPC;

  logic [31:0] mem [0:1023];
  int          wr_cnt = 0;
  logic [31:0] last_wa = 32'd0;
  logic [31:0] last_wd = 32'd0;
  logic [31:0] dbg_pc;
  int          n_tests = 0;
  int          n_fail = 0;

  mem_access_unit #(.MEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqWrite(reqWrite), .reqSize(reqSize), .reqSigned(reqSigned),
    .reqAddress(reqAddress), .reqWriteData(reqWriteData), .reqPC(reqPC),
    .reqReady(reqReady), .respValid(respValid), .respData(respData), .addrError(addrError),
    .memAddress(memAddress), .memWriteData(memWriteData), .memWriteEnable(memWriteEnable),
    .memReadData(memReadData), .memDebugPC(memDebugPC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign memReadData = mem[memAddress[11:2]];

  always @(posedge clk) begin
    if (memWriteEnable) begin
      mem[memAddress[11:2]] <= memWriteData;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= memAddress;
      last_wd <= memWriteData;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] pc,
                        output logic [31:0] data, output logic err, output int lat, output int nwr);
    int c0;
    c0 = wr_cnt;
    @(negedge clk);
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg;
    reqAddress = a; reqWriteData = wd; reqPC = pc;
    @(posedge clk); #1;
    reqValid = 1'b0;
    dbg_pc = memDebugPC;
    lat = 0; data = 32'hBAD0_BAD0; err = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      if (respValid) begin
        lat = n; data = respData; err = addrError;
        break;
      end
    end
    nwr = wr_cnt - c0;
  endtask

  task automatic exp_req(input string name, input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int e_lat, input logic [31:0] e_data, input logic e_err, input int e_nwr);
    logic [31:0] data;
    logic        err;
    int          lat;
    int          nwr;
    do_req(w, sz, sg, a, wd, 32'h0000_4000, data, err, lat, nwr);
    check_eq({name, "_lat"}, lat, e_lat);
    check_eq({name, "_data"}, data, e_data);
    check_eq({name, "_err"}, {31'b0, err}, {31'b0, e_err});
    check_eq({name, "_nwr"}, nwr, e_nwr);
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          l;
    int          nw;
    int          c0;

    reset = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b10; reqSigned = 1'b0;
    reqAddress = 32'd0; reqWriteData = 32'd0; reqPC = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'b0, reqReady}, 32'd0);
    check_eq("rst_resp", {31'b0, respValid}, 32'd0);
    check_eq("rst_err", {31'b0, addrError}, 32'd0);
    check_eq("rst_data", respData, 32'd0);
    check_eq("rst_maddr", memAddress, 32'd0);
    check_eq("rst_we", {31'b0, memWriteEnable}, 32'd0);
    check_eq("rst_pc", memDebugPC, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_eq("ready_after_rst", {31'b0, reqReady}, 32'd1);

    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0000_0ABC, d, e, l, nw);
    check_eq("ws_lat", l, 1);
    check_eq("ws_err", {31'b0, e}, 32'd0);
    check_eq("ws_data", d, 32'd0);
    check_eq("ws_nwr", nw, 1);
    check_eq("ws_addr", last_wa, 32'h10);
    check_eq("ws_wdata", last_wd, 32'hDEADBEEF);
    check_eq("ws_mem", mem[4], 32'hDEADBEEF);
    check_eq("ws_dbgpc", dbg_pc, 32'h0000_0ABC);

    exp_req("wl_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1, 32'hDEADBEEF, 1'b0, 0);
    exp_req("wl_last", 1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0, 1, mem[1023], 1'b0, 0);

    exp_req("pre_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344, 1, 32'd0, 1'b0, 1);
    exp_req("pre_30", 1'b1, 2'b10, 1'b0, 32'h30, 32'h8000FF80, 1, 32'd0, 1'b0, 1);

`ifdef SUBWORD_EN
    exp_req("sb_21", 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAA, 2, 32'd0, 1'b0, 1);
    check_eq("sb_addr", last_wa, 32'h20);
    check_eq("sb_mem", mem[8], 32'h1122AA44);
    exp_req("lbs_30", 1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 1, 32'hFFFFFF80, 1'b0, 0);
    exp_req("lhu_32", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1, 32'h00008000, 1'b0, 0);
    exp_req("lhs_30", 1'b0, 2'b01, 1'b1, 32'h30, 32'h0, 1, 32'hFFFFFF80, 1'b0, 0);
    exp_req("lbu_31", 1'b0, 2'b00, 1'b0, 32'h31, 32'h0, 1, 32'h000000FF, 1'b0, 0);
    exp_req("lbs_33", 1'b0, 2'b00, 1'b1, 32'h33, 32'h0, 1, 32'hFFFFFF80, 1'b0, 0);
    exp_req("sh_32", 1'b1, 2'b01, 1'b0, 32'h32, 32'h00001234, 2, 32'd0, 1'b0, 1);
    exp_req("wl_30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1, 32'h1234FF80, 1'b0, 0);
`else
    exp_req("sb_21", 1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFFAA, 1, 32'd0, 1'b1, 0);
    check_eq("sb_mem", mem[8], 32'h11223344);
    exp_req("lbs_30", 1'b0, 2'b00, 1'b1, 32'h30, 32'h0, 1, 32'd0, 1'b1, 0);
    exp_req("lhu_32", 1'b0, 2'b01, 1'b0, 32'h32, 32'h0, 1, 32'd0, 1'b1, 0);
    exp_req("wl_30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 1, 32'h8000FF80, 1'b0, 0);
`endif

    exp_req("f_word06", 1'b0, 2'b10, 1'b0, 32'h06, 32'h0, 1, 32'd0, 1'b1, 0);
    exp_req("f_half01", 1'b0, 2'b01, 1'b0, 32'h01, 32'h0, 1, 32'd0, 1'b1, 0);
    exp_req("f_size11", 1'b1, 2'b11, 1'b0, 32'h00, 32'h5, 1, 32'd0, 1'b1, 0);
    exp_req("f_range", 1'b1, 2'b10, 1'b0, 32'h1000, 32'h5, 1, 32'd0, 1'b1, 0);

    exp_req("pre_50", 1'b1, 2'b10, 1'b0, 32'h50, 32'h55555555, 1, 32'd0, 1'b0, 1);
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqAddress = 32'h50; reqWriteData = 32'hAAAAAAAA;
    @(posedge clk); #1;
    reqValid = 1'b0;
    c0 = wr_cnt;
    reset = 1'b0;
    #1;
    check_eq("rw_we", {31'b0, memWriteEnable}, 32'd0);
    check_eq("rw_ready", {31'b0, reqReady}, 32'd0);
    @(posedge clk); #1;
    check_eq("rw_resp0", {31'b0, respValid}, 32'd0);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rw_resp1", {31'b0, respValid}, 32'd0);
    check_eq("rw_ready1", {31'b0, reqReady}, 32'd1);
    check_eq("rw_nwr", wr_cnt - c0, 0);
    check_eq("rw_mem", mem[20], 32'h55555555);

    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqAddress = 32'h40; reqWriteData = 32'hCAFEF00D;
    @(posedge clk); #1;
    reqValid = 1'b0;
    @(posedge clk); #1;
    check_eq("bb_st_resp", {31'b0, respValid}, 32'd1);
    check_eq("bb_ready", {31'b0, reqReady}, 32'd1);
    reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'b10; reqAddress = 32'h40;
    @(posedge clk); #1;
    reqValid = 1'b0;
    check_eq("bb_gap", {31'b0, respValid}, 32'd0);
    @(posedge clk); #1;
    check_eq("bb_ld_resp", {31'b0, respValid}, 32'd1);
    check_eq("bb_ld_data", respData, 32'hCAFEF00D);
    @(posedge clk); #1;
    check_eq("bb_single", {31'b0, respValid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
